// File: rtl/serial_add_sub32_if.sv
// ---------------------------------------------------------------------------
// serial_add_sub32_if
//   Request/response bundle for the digit-serial 32-bit adder/subtractor.
//
//   Request channel  : in_valid, in_ready, a, b, m (0 add, 1 subtract)
//   Response channel : out_valid, out_ready, s, c, v
//   Status           : busy
//
//   master : the initiator (drives operands, consumes results)
//   slave  : the arithmetic unit
// ---------------------------------------------------------------------------
interface serial_add_sub32_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        m;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        c;
  logic        v;
  logic        busy;

  modport master (
    output in_valid, a, b, m, out_ready,
    input  in_ready, out_valid, s, c, v, busy
  );

  modport slave (
    input  in_valid, a, b, m, out_ready,
    output in_ready, out_valid, s, c, v, busy
  );
endinterface

// File: rtl/serial_add_sub32.sv
// ---------------------------------------------------------------------------
// serial_add_sub32
//   Multi-cycle 32-bit adder/subtractor. Computes s = a + b (m=0) or
//   s = a - b (m=1) as a + (b ^ {32{m}}) + m, DIGIT_W bits per clock,
//   giving 32/DIGIT_W compute cycles per operation.
//
//   Parameters
//     DIGIT_W : bits per cycle; one of 1, 2, 4, 8, 16, 32
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : slave side of serial_add_sub32_if
//               in_valid/in_ready : request handshake (in_ready = IDLE)
//               a, b, m           : operands and mode
//               out_valid         : result valid (DONE only)
//               out_ready         : consumer accepts result
//               s, c, v           : sum, carry out of bit 31, signed overflow
//               busy              : state != IDLE
//
//   s/c/v are dedicated registers updated only on the final digit; they
//   hold the previous result through IDLE and the next computation.
// ---------------------------------------------------------------------------
module serial_add_sub32 #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_sub32_if.slave bus
);

  localparam int unsigned N  = 32 / DIGIT_W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // working registers
  logic [31:0]   a_sh;
  logic [31:0]   b_sh;      // b already XORed with {32{m}}
  logic [31:0]   sum_sh;
  logic          carry;
  logic [CW-1:0] cnt;

  // result registers
  logic [31:0]   s_q;
  logic          c_q;
  logic          v_q;

  // digit datapath
  logic [DIGIT_W:0] dsum;
  logic             msb_cin;
  logic [31:0]      dig_top;
  logic [31:0]      sum_nxt;
  logic             last_digit;
  logic             accept;

  // -------------------------------------------------------------------------
  // Digit adder
  // -------------------------------------------------------------------------
  always_comb begin
    dsum = {1'b0, a_sh[DIGIT_W-1:0]}
         + {1'b0, b_sh[DIGIT_W-1:0]}
         + {{DIGIT_W{1'b0}}, carry};
    // sum bit = a ^ b ^ cin, so the carry into the digit MSB falls out
    // of the MSB operand bits and the MSB sum bit.
    msb_cin = a_sh[DIGIT_W-1] ^ b_sh[DIGIT_W-1] ^ dsum[DIGIT_W-1];
    // New digit enters at the top; shifting the whole register right keeps
    // the expression valid for DIGIT_W == 32 as well.
    dig_top = 32'(dsum[DIGIT_W-1:0]) << (32 - DIGIT_W);
    sum_nxt = (sum_sh >> DIGIT_W) | dig_top;
  end

  assign last_digit = (cnt == CW'(N - 1));
  assign accept     = bus.in_valid && (state == IDLE);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)        state_nxt = CALC;
      CALC:    if (last_digit)    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      CALC: ;
      DONE: bus.out_valid = 1'b1;
      default: begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
      end
    endcase
  end

  assign bus.s = s_q;
  assign bus.c = c_q;
  assign bus.v = v_q;

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b ^ {32{bus.m}};
            carry  <= bus.m;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          sum_sh <= sum_nxt;
          carry  <= dsum[DIGIT_W];
          cnt    <= cnt + 1'b1;
          if (last_digit) begin
            s_q <= sum_nxt;
            c_q <= dsum[DIGIT_W];
            v_q <= msb_cin ^ dsum[DIGIT_W];
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub32.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sub32
//   Drives three instances (DIGIT_W = 1, 4, 32) through directed corners,
//   backpressure, mid-operation reset and a random sweep. Expected results
//   are queued when a request is driven and compared when out_valid rises.
// ---------------------------------------------------------------------------
module tb_serial_add_sub32;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  exp_t        sb[$];

  int unsigned dws[3] = '{1, 4, 32};

  // per-instance stimulus and observation
  logic        iv[3];
  logic        im[3];
  logic        ordy[3];
  logic [31:0] ia[3];
  logic [31:0] ib[3];
  logic        ir[3];
  logic        ov[3];
  logic        bsy[3];
  logic        oc[3];
  logic        ovf[3];
  logic [31:0] os[3];

  serial_add_sub32_if if1();
  serial_add_sub32_if if4();
  serial_add_sub32_if if32();

  serial_add_sub32 #(.DIGIT_W(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_add_sub32 #(.DIGIT_W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_add_sub32 #(.DIGIT_W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  assign if1.in_valid  = iv[0];   assign if1.a  = ia[0];  assign if1.b  = ib[0];
  assign if1.m         = im[0];   assign if1.out_ready  = ordy[0];
  assign if4.in_valid  = iv[1];   assign if4.a  = ia[1];  assign if4.b  = ib[1];
  assign if4.m         = im[1];   assign if4.out_ready  = ordy[1];
  assign if32.in_valid = iv[2];   assign if32.a = ia[2];  assign if32.b = ib[2];
  assign if32.m        = im[2];   assign if32.out_ready = ordy[2];

  assign ir[0] = if1.in_ready;  assign ov[0] = if1.out_valid;  assign bsy[0] = if1.busy;
  assign os[0] = if1.s;         assign oc[0] = if1.c;          assign ovf[0] = if1.v;
  assign ir[1] = if4.in_ready;  assign ov[1] = if4.out_valid;  assign bsy[1] = if4.busy;
  assign os[1] = if4.s;         assign oc[1] = if4.c;          assign ovf[1] = if4.v;
  assign ir[2] = if32.in_ready; assign ov[2] = if32.out_valid; assign bsy[2] = if32.busy;
  assign os[2] = if32.s;        assign oc[2] = if32.c;         assign ovf[2] = if32.v;

  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 33-bit reference: flags derived from operand/result signs
  function automatic exp_t model(input logic [31:0] a_i, input logic [31:0] b_i,
                                 input logic m_i);
    logic [31:0] bb;
    logic [32:0] r;
    exp_t        e;
    bb  = b_i ^ {32{m_i}};
    r   = {1'b0, a_i} + {1'b0, bb} + 33'(m_i);
    e.s = r[31:0];
    e.c = r[32];
    e.v = (a_i[31] == bb[31]) && (r[31] != a_i[31]);
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] s_i, input logic c_i, input logic v_i);
    exp_t e;
    e.s = s_i; e.c = c_i; e.v = v_i;
    return e;
  endfunction

  task automatic accept(input int k, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic m_i, input exp_t e);
    int unsigned w;
    w = 0;
    while (!ir[k] && w < 200) begin tick(); w++; end
    chk("req_ready", 32'(ir[k]), 32'd1);
    iv[k] = 1'b1; ia[k] = a_i; ib[k] = b_i; im[k] = m_i;
    sb.push_back(e);
    tick();
    // operands need not be held after acceptance
    iv[k] = 1'b0; ia[k] = $urandom; ib[k] = $urandom; im[k] = 1'($urandom_range(0, 1));
    chk("busy_after_accept", 32'(bsy[k]), 32'd1);
    chk("in_ready_in_calc", 32'(ir[k]), 32'd0);
  endtask

  task automatic wait_done(input int k, output exp_t e);
    int unsigned lat;
    lat = 0;
    e   = '0;
    while (!ov[k] && lat < 100) begin tick(); lat++; end
    chk("latency", lat, 32 / dws[k]);
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL sb_underflow: observed empty queue, expected a pending result");
    end else begin
      e = sb.pop_front();
      chk("s", os[k], e.s);
      chk("c", 32'(oc[k]), 32'(e.c));
      chk("v", 32'(ovf[k]), 32'(e.v));
    end
  endtask

  task automatic release_result(input int k);
    ordy[k] = 1'b1;
    tick();
    ordy[k] = 1'b0;
    chk("out_valid_after_xfer", 32'(ov[k]), 32'd0);
    chk("in_ready_after_xfer", 32'(ir[k]), 32'd1);
    chk("busy_after_xfer", 32'(bsy[k]), 32'd0);
  endtask

  task automatic run_op(input int k, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic m_i, input exp_t e_req);
    exp_t e;
    accept(k, a_i, b_i, m_i, e_req);
    wait_done(k, e);
    release_result(k);
  endtask

  task automatic check_reset_state(input int k);
    chk("rst_out_valid", 32'(ov[k]), 32'd0);
    chk("rst_busy", 32'(bsy[k]), 32'd0);
    chk("rst_in_ready", 32'(ir[k]), 32'd1);
    chk("rst_s", os[k], 32'd0);
    chk("rst_c", 32'(oc[k]), 32'd0);
    chk("rst_v", 32'(ovf[k]), 32'd0);
  endtask

  // -------------------------------------------------------------------------
  initial begin : main
    exp_t        e1;
    exp_t        e2;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rm;

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; im[k] = 1'b0; ordy[k] = 1'b0; ia[k] = '0; ib[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_state(k);
    rst_n = 1'b1;
    tick();

    // directed arithmetic on every width
    for (int k = 0; k < 3; k++) begin
      run_op(k, 32'd16,        32'd14, 1'b0, mk(32'd30,        1'b0, 1'b0));
      run_op(k, 32'd20,        32'd15, 1'b1, mk(32'd5,         1'b1, 1'b0));
      run_op(k, 32'd14,        32'd25, 1'b1, mk(32'hFFFF_FFF5, 1'b0, 1'b0));
      run_op(k, 32'h7FFF_FFFF, 32'd1,  1'b0, mk(32'h8000_0000, 1'b0, 1'b1));
      run_op(k, 32'hFFFF_FFFF, 32'd1,  1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
      run_op(k, 32'h8000_0000, 32'd1,  1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
    end

    // backpressure with a competing request held on in_valid (DIGIT_W=1)
    accept(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, model(32'h1234_5678, 32'h0F0F_0F0F, 1'b0));
    wait_done(0, e1);
    iv[0] = 1'b1; ia[0] = 32'hCAFE_0000; ib[0] = 32'h0000_BEEF; im[0] = 1'b1;
    repeat (5) begin
      tick();
      chk("bp_out_valid", 32'(ov[0]), 32'd1);
      chk("bp_in_ready", 32'(ir[0]), 32'd0);
      chk("bp_s_stable", os[0], e1.s);
      chk("bp_c_stable", 32'(oc[0]), 32'(e1.c));
      chk("bp_v_stable", 32'(ovf[0]), 32'(e1.v));
    end
    ordy[0] = 1'b1;
    tick();
    ordy[0] = 1'b0;
    chk("bp_xfer_out_valid", 32'(ov[0]), 32'd0);
    chk("bp_not_taken_at_xfer", 32'(bsy[0]), 32'd0);
    sb.push_back(model(32'hCAFE_0000, 32'h0000_BEEF, 1'b1));
    tick();
    iv[0] = 1'b0;
    chk("bp_taken_next_edge", 32'(bsy[0]), 32'd1);
    chk("hold_s_during_calc", os[0], e1.s);
    wait_done(0, e2);
    release_result(0);

    // reset at digit 10 of an operation; last result is nonzero
    accept(0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b0, model(32'hDEAD_BEEF, 32'h0123_4567, 1'b0));
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check_reset_state(0);
    void'(sb.pop_front());
    iv[0] = 1'b1; ia[0] = 32'h5555_5555; ib[0] = 32'h1111_1111; im[0] = 1'b0;
    tick();
    chk("no_capture_in_reset", 32'(bsy[0]), 32'd0);
    iv[0] = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("no_stale_out_valid", 32'(ov[0]), 32'd0);
    chk("no_stale_busy", 32'(bsy[0]), 32'd0);
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, mk(32'h0000_0100, 1'b0, 1'b0));

    // random sweep per width
    for (int k = 0; k < 3; k++) begin
      for (int unsigned i = 0; i < 1000; i++) begin
        ra = $urandom;
        rb = $urandom;
        rm = 1'($urandom_range(0, 1));
        run_op(k, ra, rb, rm, model(ra, rb, rm));
      end
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
